channel_readout_arbiter: RTL and testbench
==========================================

Name: channel_readout_arbiter

Overview:
- Round-robin readout scheduler for the four TDS channel FIFOs of the 4-lane receiver (120-bit words, empty flags, read strobes).
- Drains non-empty enabled channels in bounded bursts into one valid/ready stream tagged with the channel ID, for the logging/transmit path.
- Owns the per-channel FIFO soft-reset and data_tran_stop controls, and sequences flushes.
- Sits in the clk160 readout domain, between the channel decoders and the downstream packetiser.

Parameters:
- MAX_BURST, 8, max words taken from one channel per grant (1..255).
- FLUSH_CYCLES, 4, cycles channel_fifo_s_reset is held high during a flush (1..15).

Ports:
- clk160  in  1  readout clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  4  per-channel enable mask.
- flush  in  1  single-cycle flush request.
- channel_fifo_empty  in  4  FIFO empty flags, bit i = channel i.
- channel_data  in  480  FIFO read data, channel i at [120*i+119:120*i]; valid one cycle after read strobe.
- channel_data_read  out  4  FIFO read strobes, one-hot or zero.
- channel_fifo_s_reset  out  4  FIFO soft resets.
- data_tran_stop  out  4  per-channel write-stop.
- out_data  out  120  forwarded word.
- out_channel  out  2  source channel of out_data.
- out_valid  out  1  out_data/out_channel valid.
- out_ready  in  1  downstream accept.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset_n low, async): state=IDLE, all outputs 0, last_grant=3, burst_cnt=0, flush_pending=0.
- Eligible channel i = enable[i] & ~channel_fifo_empty[i].
- States: IDLE, READ, CAPT, OUT, FLUSH.
- IDLE:
  - If flush_pending: go to FLUSH.
  - Else if any channel is eligible: grant the first eligible channel scanning last_grant+1, +2, +3, +4 (mod 4), set burst_cnt=0, go to READ.
- READ: channel_data_read[grant]=1 for exactly one cycle; go to CAPT.
- CAPT: register the channel_data slice for grant into out_data, out_channel=grant, out_valid=1, burst_cnt+1; go to OUT.
- OUT:
  - Hold out_data, out_channel and out_valid stable until out_ready=1. Transfer occurs on the cycle out_valid & out_ready.
  - On transfer, out_valid=0 next cycle.
  - Then, if burst_cnt<MAX_BURST, grant still eligible and no flush_pending: go to READ on the same channel.
  - Otherwise set last_grant=grant and go to IDLE.
- Throughput: 3 cycles per word minimum with out_ready tied high. Read-to-out_valid latency is 2 cycles.
- Flush handling:
  - A flush pulse in any state sets flush_pending.
  - An in-flight word is always completed: no data is dropped once read is issued.
  - FLUSH state: channel_fifo_s_reset=4'b1111 for FLUSH_CYCLES cycles, counted in FLUSH, then clear flush_pending, set last_grant=3, go to IDLE.
  - A flush during FLUSH is absorbed (no extension).
- data_tran_stop[i] = ~enable[i] | (state==FLUSH), registered (1-cycle delay).
- Enable change:
  - If enable[grant] drops mid-burst, the current word still completes; the burst ends at the next OUT exit.
  - enable=0 keeps the block in IDLE.
- Empty is re-sampled in OUT before each continuation read. A read is never issued to an empty FIFO.
- At most one channel_data_read bit is high in any cycle.
- No read is issued while out_valid=1.

Optional Feature:
- Macro: ARB_WORD_COUNT_EN.
- With it defined:
  - Adds output word_count, 64 bits: four 16-bit counters, channel i at [16*i+15:16*i].
  - Counter i increments on each transfer with out_channel=i and wraps 0xFFFF→0.
  - Counters clear on reset_n and on FLUSH entry.
- Without it: the port and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single channel: enable=4'b0001, ch0 holds 3 words (A,B,C), out_ready=1 → out_data A,B,C with out_channel=0, each out_valid 3 cycles apart; IDLE after C; channel_data_read[0] pulsed exactly 3 times.
- Round robin with burst cap: MAX_BURST=8, all enabled, each FIFO holds 10 words → order is ch0×8, ch1×8, ch2×8, ch3×8, ch0×2, ch1×2, ch2×2, ch3×2; 40 transfers total.
- Backpressure: out_ready=0 for 20 cycles after first out_valid → out_data/out_channel stable and no read strobes during the stall; the next read occurs 1 cycle after the transfer.
- Flush mid-burst: flush pulsed while in OUT on ch2 → current word transfers, then channel_fifo_s_reset=4'hF for exactly 4 cycles and data_tran_stop=4'hF; next grant starts at ch0.
- Reset mid-operation: reset_n low during CAPT → all outputs 0 immediately; after release, grant restarts at lowest eligible channel.
- Enable drop: enable[1] cleared during a ch1 burst → at most the in-flight word emitted, then no further ch1 reads; data_tran_stop[1]=1 one cycle after the clear.

Source files
------------

// File: rtl/channel_readout_arbiter.sv
// Round-robin readout scheduler for the four TDS channel FIFOs, with flush sequencing.
// Optional per-channel transfer counters on the word_count port when ARB_WORD_COUNT_EN is defined.
module channel_readout_arbiter #(
    parameter int MAX_BURST    = 8,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic         clk160,
    input  logic         reset_n,
    input  logic [3:0]   enable,
    input  logic         flush,
    input  logic [3:0]   channel_fifo_empty,
    input  logic [479:0] channel_data,
    output logic [3:0]   channel_data_read,
    output logic [3:0]   channel_fifo_s_reset,
    output logic [3:0]   data_tran_stop,
    output logic [119:0] out_data,
    output logic [1:0]   out_channel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
`ifdef ARB_WORD_COUNT_EN
    ,
    output logic [63:0]  word_count
`endif
);

    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);
    localparam logic [3:0] FLUSH_LAST  = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        OUT,
        FLUSH
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  grant;
    logic [1:0]  last_grant;
    logic [1:0]  rr_pick;
    logic        rr_found;
    logic [7:0]  burst_cnt;
    logic [3:0]  flush_cnt;
    logic        flush_pending;
    logic [3:0]  eligible;
    logic        transfer;
    logic        continue_burst;

    assign eligible       = enable & ~channel_fifo_empty;
    assign transfer       = out_valid & out_ready;
    assign continue_burst = (burst_cnt < BURST_LIMIT) & eligible[grant] & ~flush_pending;
    assign busy           = (state != IDLE);

    // Scan starts just after the last served channel; offset 4 wraps back onto it.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = last_grant;
        for (int k = 1; k <= 4; k++) begin
            if (!rr_found && eligible[last_grant + 2'(k)]) begin
                rr_found = 1'b1;
                rr_pick  = last_grant + 2'(k);
            end
        end
    end

    always_comb begin
        state_next           = state;
        channel_data_read    = 4'b0000;
        channel_fifo_s_reset = 4'b0000;
        case (state)
            IDLE: begin
                if (flush_pending) begin
                    state_next = FLUSH;
                end else if (rr_found) begin
                    state_next = READ;
                end
            end
            READ: begin
                channel_data_read = 4'b0001 << grant;
                state_next        = CAPT;
            end
            CAPT: begin
                state_next = OUT;
            end
            OUT: begin
                if (transfer) begin
                    state_next = continue_burst ? READ : IDLE;
                end
            end
            FLUSH: begin
                channel_fifo_s_reset = 4'b1111;
                if (flush_cnt == FLUSH_LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk160 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk160 or negedge reset_n) begin
        if (!reset_n) begin
            grant          <= 2'd0;
            last_grant     <= 2'd3;
            burst_cnt      <= 8'd0;
            flush_cnt      <= 4'd0;
            flush_pending  <= 1'b0;
            out_data       <= '0;
            out_channel    <= 2'd0;
            out_valid      <= 1'b0;
            data_tran_stop <= 4'b0000;
        end else begin
            data_tran_stop <= ~enable | {4{state == FLUSH}};
            // A request arriving while already flushing is absorbed.
            if (flush && (state != FLUSH)) begin
                flush_pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (flush_pending) begin
                        flush_cnt <= 4'd0;
                    end else if (rr_found) begin
                        grant     <= rr_pick;
                        burst_cnt <= 8'd0;
                    end
                end
                CAPT: begin
                    out_data    <= channel_data[int'(grant) * 120 +: 120];
                    out_channel <= grant;
                    out_valid   <= 1'b1;
                    burst_cnt   <= burst_cnt + 8'd1;
                end
                OUT: begin
                    if (transfer) begin
                        out_valid <= 1'b0;
                        if (!continue_burst) begin
                            last_grant <= grant;
                        end
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + 4'd1;
                    if (flush_cnt == FLUSH_LAST) begin
                        flush_pending <= 1'b0;
                        last_grant    <= 2'd3;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ARB_WORD_COUNT_EN
    logic [15:0] word_cnt [4];

    // Counters restart whenever a flush sequence begins.
    always_ff @(posedge clk160 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                word_cnt[i] <= 16'd0;
            end
        end else if ((state == IDLE) && flush_pending) begin
            for (int i = 0; i < 4; i++) begin
                word_cnt[i] <= 16'd0;
            end
        end else if (transfer) begin
            word_cnt[out_channel] <= word_cnt[out_channel] + 16'd1;
        end
    end

    assign word_count = {word_cnt[3], word_cnt[2], word_cnt[1], word_cnt[0]};
`endif

endmodule

// File: tb/tb_channel_readout_arbiter.sv
// Directed bench for channel_readout_arbiter: FIFO model, scoreboard of expected words,
// and immediate assertions at every comparison point.
module tb_channel_readout_arbiter;

    typedef struct packed {
        logic [1:0]   ch;
        logic [119:0] data;
    } exp_t;

    logic         clk160 = 1'b0;
    logic         reset_n;
    logic [3:0]   enable;
    logic         flush;
    logic [3:0]   channel_fifo_empty;
    logic [479:0] channel_data;
    logic [3:0]   channel_data_read;
    logic [3:0]   channel_fifo_s_reset;
    logic [3:0]   data_tran_stop;
    logic [119:0] out_data;
    logic [1:0]   out_channel;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
`ifdef ARB_WORD_COUNT_EN
    logic [63:0]  word_count;
`endif

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int read_count [4];
    int read_cycles [$];
    int xfer_cycles [$];
    logic [119:0] fifo_q [4][$];
    logic [119:0] data_reg [4];
    exp_t exp_q [$];

    channel_readout_arbiter #(.MAX_BURST(8), .FLUSH_CYCLES(4)) dut (
        .clk160(clk160),
        .reset_n(reset_n),
        .enable(enable),
        .flush(flush),
        .channel_fifo_empty(channel_fifo_empty),
        .channel_data(channel_data),
        .channel_data_read(channel_data_read),
        .channel_fifo_s_reset(channel_fifo_s_reset),
        .data_tran_stop(data_tran_stop),
        .out_data(out_data),
        .out_channel(out_channel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy)
`ifdef ARB_WORD_COUNT_EN
        ,
        .word_count(word_count)
`endif
    );

    always #5 clk160 = ~clk160;

    always @(posedge clk160) cycle++;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(string tag, logic [127:0] observed, logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // FIFO model plus output monitor; protocol checks run before the model pops.
    always @(negedge clk160) begin
        if (reset_n) begin
            if (channel_data_read != 4'b0000) begin
                check_output("read_onehot", 128'($onehot0(channel_data_read)), 128'(1));
                check_output("read_while_valid", 128'(out_valid), 128'(0));
                for (int i = 0; i < 4; i++) begin
                    if (channel_data_read[i]) begin
                        check_output("read_nonempty", 128'(fifo_q[i].size() != 0), 128'(1));
                        read_count[i]++;
                        read_cycles.push_back(cycle);
                    end
                end
            end
            if (out_valid && out_ready) begin
                xfer_cycles.push_back(cycle);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $error("[TB] FAIL unexpected_xfer: observed ch%0d %0h expected no transfer", out_channel, out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    assert ((out_channel === e.ch) && (out_data === e.data)) else begin
                        errors++;
                        $error("[TB] FAIL xfer: observed ch%0d %0h expected ch%0d %0h", out_channel, out_data, e.ch, e.data);
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (channel_fifo_s_reset[i]) begin
                fifo_q[i].delete();
            end else if (channel_data_read[i] && (fifo_q[i].size() != 0)) begin
                data_reg[i] = fifo_q[i].pop_front();
            end
            channel_fifo_empty[i] = (fifo_q[i].size() == 0);
            channel_data[i*120 +: 120] = data_reg[i];
        end
    end

    task automatic step();
        @(posedge clk160);
        #1;
    endtask

    function automatic logic [119:0] make_word(int ch, int idx);
        return {8'(ch), 16'(idx), 32'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    task automatic load_word(int ch, logic [119:0] w, bit expect_it);
        exp_t e;
        fifo_q[ch].push_back(w);
        if (expect_it) begin
            e.ch   = 2'(ch);
            e.data = w;
            exp_q.push_back(e);
        end
    endtask

    task automatic expect_word(int ch, logic [119:0] w);
        exp_t e;
        e.ch   = 2'(ch);
        e.data = w;
        exp_q.push_back(e);
    endtask

    task automatic clear_tracking();
        for (int i = 0; i < 4; i++) begin
            read_count[i] = 0;
        end
        read_cycles.delete();
        xfer_cycles.delete();
    endtask

    task automatic reset_dut();
        reset_n   = 1'b0;
        enable    = 4'b0000;
        flush     = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            fifo_q[i].delete();
            data_reg[i] = '0;
        end
        clear_tracking();
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic wait_drain(string tag, int budget);
        int n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            step();
            n++;
        end
        check_output({tag, "_drained"}, 128'(exp_q.size()), 128'(0));
        repeat (4) step();
        check_output({tag, "_idle"}, 128'(busy), 128'(0));
    endtask

    task automatic wait_valid(string tag, int budget);
        int n = 0;
        while (!out_valid && (n < budget)) begin
            step();
            n++;
        end
        check_output({tag, "_valid_seen"}, 128'(out_valid), 128'(1));
    endtask

    initial begin
        logic [119:0] w;
        logic [119:0] rr_words [4][10];
        logic [119:0] held_data;
        logic [1:0]   held_ch;
        int           d;
        int           n;
        int           seen;

        // ---------------- reset state ----------------
        reset_n   = 1'b1;
        enable    = 4'b0000;
        flush     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_reg[i] = '0;
            read_count[i] = 0;
        end
        #2 reset_n = 1'b0;
        #1;
        check_output("rst_read", 128'(channel_data_read), 128'(0));
        check_output("rst_sreset", 128'(channel_fifo_s_reset), 128'(0));
        check_output("rst_stop", 128'(data_tran_stop), 128'(0));
        check_output("rst_data", 128'(out_data), 128'(0));
        check_output("rst_channel", 128'(out_channel), 128'(0));
        check_output("rst_valid", 128'(out_valid), 128'(0));
        check_output("rst_busy", 128'(busy), 128'(0));
        reset_dut();

        // ---------------- single channel ----------------
        $display("[TB] single channel");
        for (int i = 0; i < 3; i++) begin
            load_word(0, make_word(0, i), 1'b1);
        end
        enable    = 4'b0001;
        out_ready = 1'b1;
        step();
        check_output("single_stop", 128'(data_tran_stop), 128'(4'b1110));
        wait_drain("single", 100);
        check_output("single_reads", 128'(read_count[0]), 128'(3));
        d = (xfer_cycles.size() >= 3) ? xfer_cycles[1] - xfer_cycles[0] : -1;
        check_output("single_gap1", 128'(d), 128'(3));
        d = (xfer_cycles.size() >= 3) ? xfer_cycles[2] - xfer_cycles[1] : -1;
        check_output("single_gap2", 128'(d), 128'(3));
        d = ((xfer_cycles.size() >= 1) && (read_cycles.size() >= 1)) ? xfer_cycles[0] - read_cycles[0] : -1;
        check_output("single_latency", 128'(d), 128'(2));

        // ---------------- round robin with burst cap ----------------
        $display("[TB] round robin");
        reset_dut();
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 10; i++) begin
                rr_words[c][i] = make_word(c, i);
                load_word(c, rr_words[c][i], 1'b0);
            end
        end
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 8; i++) begin
                expect_word(c, rr_words[c][i]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            for (int i = 8; i < 10; i++) begin
                expect_word(c, rr_words[c][i]);
            end
        end
        enable    = 4'b1111;
        out_ready = 1'b1;
        wait_drain("rr", 400);
        check_output("rr_total", 128'(xfer_cycles.size()), 128'(40));
`ifdef ARB_WORD_COUNT_EN
        check_output("rr_word_count", 128'(word_count), 128'({4{16'd10}}));
`endif

        // ---------------- backpressure ----------------
        $display("[TB] backpressure");
        reset_dut();
        load_word(0, make_word(0, 0), 1'b1);
        load_word(0, make_word(0, 1), 1'b1);
        enable = 4'b0001;
        wait_valid("bp", 50);
        held_data = out_data;
        held_ch   = out_channel;
        for (int i = 0; i < 20; i++) begin
            step();
            check_output("bp_data_stable", 128'(out_data), 128'(held_data));
            check_output("bp_ch_stable", 128'(out_channel), 128'(held_ch));
            check_output("bp_no_read", 128'(channel_data_read), 128'(0));
            check_output("bp_valid_held", 128'(out_valid), 128'(1));
        end
        out_ready = 1'b1;
        wait_drain("bp", 100);
        d = ((read_cycles.size() >= 2) && (xfer_cycles.size() >= 1)) ? read_cycles[1] - xfer_cycles[0] : -1;
        check_output("bp_next_read", 128'(d), 128'(1));

        // ---------------- flush mid-burst ----------------
        $display("[TB] flush mid-burst");
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            load_word(2, make_word(2, i), i == 0);
        end
        enable = 4'b0100;
        wait_valid("flush", 50);
        step();
        flush = 1'b1;
        step();
        flush     = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((channel_fifo_s_reset == 4'b0000) && (n < 20)) begin
            step();
            n++;
        end
        check_output("flush_sreset", 128'(channel_fifo_s_reset), 128'(4'hF));
        n = 0;
        while ((channel_fifo_s_reset == 4'hF) && (n < 20)) begin
            n++;
            if (n == 2) begin
                check_output("flush_stop", 128'(data_tran_stop), 128'(4'hF));
            end
            step();
        end
        check_output("flush_len", 128'(n), 128'(4));
        wait_drain("flush", 20);
        check_output("flush_reads", 128'(read_count[2]), 128'(1));
        load_word(3, make_word(3, 0), 1'b0);
        w = make_word(0, 0);
        load_word(0, w, 1'b1);
        expect_word(3, fifo_q[3][0]);
        enable = 4'b1111;
        wait_drain("flush_regrant", 50);

        // ---------------- reset mid-operation ----------------
        $display("[TB] reset during capture");
        clear_tracking();
        enable = 4'b0110;
        load_word(1, make_word(1, 0), 1'b1);
        load_word(2, make_word(2, 0), 1'b0);
        w = make_word(2, 1);
        load_word(2, w, 1'b0);
        n = 0;
        while (!channel_data_read[2] && (n < 50)) begin
            step();
            n++;
        end
        check_output("rstop_read2", 128'(channel_data_read), 128'(4'b0100));
        step();
        reset_n = 1'b0;
        #1;
        check_output("rstop_valid", 128'(out_valid), 128'(0));
        check_output("rstop_data", 128'(out_data), 128'(0));
        check_output("rstop_read", 128'(channel_data_read), 128'(0));
        check_output("rstop_busy", 128'(busy), 128'(0));
        check_output("rstop_stop", 128'(data_tran_stop), 128'(0));
        check_output("rstop_drained", 128'(exp_q.size()), 128'(0));
        load_word(1, make_word(1, 1), 1'b1);
        expect_word(2, w);
        step();
        step();
        reset_n = 1'b1;
        wait_drain("rstop", 50);

        // ---------------- enable drop ----------------
        $display("[TB] enable drop");
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            load_word(1, make_word(1, i), i < 2);
        end
        enable    = 4'b0010;
        out_ready = 1'b1;
        seen = 0;
        n = 0;
        while ((seen < 2) && (n < 100)) begin
            step();
            n++;
            if (channel_data_read[1]) begin
                seen++;
            end
        end
        step();
        check_output("drop_stop_before", 128'(data_tran_stop[1]), 128'(0));
        enable = 4'b0000;
        step();
        check_output("drop_stop_after", 128'(data_tran_stop), 128'(4'hF));
        repeat (30) step();
        wait_drain("drop", 10);
        check_output("drop_reads", 128'(read_count[1]), 128'(2));
        check_output("drop_fifo_left", 128'(fifo_q[1].size()), 128'(3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
